// File: rtl/charattr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : charattr_encoder
// Purpose  : Packs terminal write commands into 32-bit charattr words and
//            writes one to four cells (double width/height) to text memory.
//            Define CHARATTR_CLIP_EN to skip cells outside the screen.
// Revision : 1.0
// ============================================================================
module charattr_encoder #(
    parameter int COLUMNS    = 80,
    parameter int ROWS       = 51,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_gfx,
    input  logic [9:0]            cmd_code,
    input  logic [19:0]           cmd_gfx_bits,
    input  logic                  cmd_mosaic,
    input  logic [6:0]            cmd_x,
    input  logic [5:0]            cmd_y,
    input  logic [3:0]            attr_background,
    input  logic [3:0]            attr_foreground,
    input  logic [3:0]            attr_pattern,
    input  logic [1:0]            attr_function,
    input  logic                  attr_underline,
    input  logic                  attr_invert,
    input  logic [1:0]            attr_blink,
    input  logic                  attr_size_horz,
    input  logic                  attr_size_vert,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_address,
    output logic [31:0]           wr_data,
    output logic                  cmd_done,
    output logic [7:0]            next_x
);

`ifdef CHARATTR_CLIP_EN
    localparam logic c_clip_en = 1'b1;
`else
    localparam logic c_clip_en = 1'b0;
`endif

    typedef struct packed {
        logic        gfx;
        logic [9:0]  code;
        logic [19:0] gfx_bits;
        logic        mosaic;
        logic [6:0]  x;
        logic [5:0]  y;
        logic [3:0]  bg;
        logic [3:0]  fg;
        logic [3:0]  pattern;
        logic [1:0]  func;
        logic        underline;
        logic        invert;
        logic [1:0]  blink;
        logic        size_horz;
        logic        size_vert;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    cmd_t                  r_cmd;
    cmd_t                  w_cmd_in;
    logic                  r_part_h;
    logic                  r_part_v;
    logic                  r_cmd_ready;
    logic                  r_wr_valid;
    logic [ADDR_WIDTH-1:0] r_wr_address;
    logic [31:0]           r_wr_data;
    logic                  r_cmd_done;
    logic [7:0]            r_next_x;
    logic                  w_last;
    logic                  w_next_h;
    logic                  w_next_v;

    // Graphic commands are always a single cell regardless of size attributes.
    function automatic logic f_wide(input cmd_t c);
        return c.size_horz & ~c.gfx;
    endfunction

    function automatic logic f_tall(input cmd_t c);
        return c.size_vert & ~c.gfx;
    endfunction

    function automatic logic [31:0] f_word(input cmd_t c, input logic ph, input logic pv);
        if (c.gfx)
            return {c.bg, c.fg, c.gfx_bits[19:10],
                    (c.mosaic ? 4'b1000 : 4'b0100), c.gfx_bits[9:0]};
        else
            return {c.bg, c.fg, c.pattern, c.func, c.underline, c.invert, c.blink,
                    pv, ph, c.size_vert, c.size_horz, c.code};
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] f_addr(input cmd_t c, input logic ph, input logic pv);
        logic [31:0] t;
        t = (32'(c.y) + 32'(pv)) * 32'(COLUMNS) + 32'(c.x) + 32'(ph);
        return t[ADDR_WIDTH-1:0];
    endfunction

    function automatic logic f_writable(input cmd_t c, input logic ph, input logic pv);
        logic in_range;
        in_range = (32'(c.x) + 32'(ph) < 32'(COLUMNS)) &&
                   (32'(c.y) + 32'(pv) < 32'(ROWS));
        return !c_clip_en || in_range;
    endfunction

    always_comb begin
        w_cmd_in = '{gfx:       cmd_gfx,
                     code:      cmd_code,
                     gfx_bits:  cmd_gfx_bits,
                     mosaic:    cmd_mosaic,
                     x:         cmd_x,
                     y:         cmd_y,
                     bg:        attr_background,
                     fg:        attr_foreground,
                     pattern:   attr_pattern,
                     func:      attr_function,
                     underline: attr_underline,
                     invert:    attr_invert,
                     blink:     attr_blink,
                     size_horz: attr_size_horz,
                     size_vert: attr_size_vert};
    end

    // Cell order: (x,y), (x+1,y), (x,y+1), (x+1,y+1) restricted to the W x H set.
    always_comb begin
        w_last   = 1'b1;
        w_next_h = 1'b0;
        w_next_v = 1'b0;
        if (!r_part_h && f_wide(r_cmd)) begin
            w_last   = 1'b0;
            w_next_h = 1'b1;
            w_next_v = r_part_v;
        end else if (!r_part_v && f_tall(r_cmd)) begin
            w_last   = 1'b0;
            w_next_h = 1'b0;
            w_next_v = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cmd        <= '0;
            r_part_h     <= 1'b0;
            r_part_v     <= 1'b0;
            r_cmd_ready  <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_wr_address <= '0;
            r_wr_data    <= '0;
            r_cmd_done   <= 1'b0;
            r_next_x     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_cmd_ready && cmd_valid) begin
                        r_cmd        <= w_cmd_in;
                        r_part_h     <= 1'b0;
                        r_part_v     <= 1'b0;
                        r_wr_valid   <= f_writable(w_cmd_in, 1'b0, 1'b0);
                        r_wr_address <= f_addr(w_cmd_in, 1'b0, 1'b0);
                        r_wr_data    <= f_word(w_cmd_in, 1'b0, 1'b0);
                        r_cmd_ready  <= 1'b0;
                        r_state      <= ST_EMIT;
                    end else begin
                        r_cmd_ready  <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    // A skipped cell (wr_valid low) still occupies one cycle here.
                    if (!r_wr_valid || wr_ready) begin
                        if (w_last) begin
                            r_wr_valid <= 1'b0;
                            r_cmd_done <= 1'b1;
                            r_next_x   <= {1'b0, r_cmd.x} + 8'd1 + {7'd0, f_wide(r_cmd)};
                            r_state    <= ST_DONE;
                        end else begin
                            r_part_h     <= w_next_h;
                            r_part_v     <= w_next_v;
                            r_wr_valid   <= f_writable(r_cmd, w_next_h, w_next_v);
                            r_wr_address <= f_addr(r_cmd, w_next_h, w_next_v);
                            r_wr_data    <= f_word(r_cmd, w_next_h, w_next_v);
                        end
                    end
                end
                ST_DONE: begin
                    r_cmd_done  <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign wr_valid   = r_wr_valid;
    assign wr_address = r_wr_address;
    assign wr_data    = r_wr_data;
    assign cmd_done   = r_cmd_done;
    assign next_x     = r_next_x;

endmodule
`default_nettype wire

// File: tb/tb_charattr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_charattr_encoder
// Purpose  : Directed and randomized checks of charattr_encoder against a
//            cell-list reference model.
// Revision : 1.0
// ============================================================================
module tb_charattr_encoder;

    localparam int COLUMNS    = 80;
    localparam int ROWS       = 51;
    localparam int ADDR_WIDTH = 13;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_gfx;
    logic [9:0]            cmd_code;
    logic [19:0]           cmd_gfx_bits;
    logic                  cmd_mosaic;
    logic [6:0]            cmd_x;
    logic [5:0]            cmd_y;
    logic [3:0]            attr_background;
    logic [3:0]            attr_foreground;
    logic [3:0]            attr_pattern;
    logic [1:0]            attr_function;
    logic                  attr_underline;
    logic                  attr_invert;
    logic [1:0]            attr_blink;
    logic                  attr_size_horz;
    logic                  attr_size_vert;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_address;
    logic [31:0]           wr_data;
    logic                  cmd_done;
    logic [7:0]            next_x;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    charattr_encoder #(
        .COLUMNS    (COLUMNS),
        .ROWS       (ROWS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_gfx         (cmd_gfx),
        .cmd_code        (cmd_code),
        .cmd_gfx_bits    (cmd_gfx_bits),
        .cmd_mosaic      (cmd_mosaic),
        .cmd_x           (cmd_x),
        .cmd_y           (cmd_y),
        .attr_background (attr_background),
        .attr_foreground (attr_foreground),
        .attr_pattern    (attr_pattern),
        .attr_function   (attr_function),
        .attr_underline  (attr_underline),
        .attr_invert     (attr_invert),
        .attr_blink      (attr_blink),
        .attr_size_horz  (attr_size_horz),
        .attr_size_vert  (attr_size_vert),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_address      (wr_address),
        .wr_data         (wr_data),
        .cmd_done        (cmd_done),
        .next_x          (next_x)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Word built field by field, most significant first.
    function automatic logic [31:0] model_word(input int gfx, code, gbits, mosaic, bg, fg, pat,
                                               func, ul, inv, blink, sh, sv, dx, dy);
        longint v;
        v = longint'(bg);
        v = v * 16 + fg;
        if (gfx != 0) begin
            v = v * 1024 + gbits / 1024;
            v = v * 16 + ((mosaic != 0) ? 8 : 4);
            v = v * 1024 + gbits % 1024;
        end else begin
            v = v * 16 + pat;
            v = v * 4 + func;
            v = v * 2 + ul;
            v = v * 2 + inv;
            v = v * 4 + blink;
            v = v * 2 + dy;
            v = v * 2 + dx;
            v = v * 2 + sv;
            v = v * 2 + sh;
            v = v * 1024 + code;
        end
        return v[31:0];
    endfunction

    function automatic bit model_writable(input int cx, input int cy);
`ifdef CHARATTR_CLIP_EN
        return (cx < COLUMNS) && (cy < ROWS);
`else
        return (cx >= 0) && (cy >= 0);
`endif
    endfunction

    task automatic scramble_inputs();
        cmd_gfx         = 1'($urandom);
        cmd_code        = 10'($urandom);
        cmd_gfx_bits    = 20'($urandom);
        cmd_mosaic      = 1'($urandom);
        cmd_x           = 7'($urandom);
        cmd_y           = 6'($urandom);
        attr_background = 4'($urandom);
        attr_foreground = 4'($urandom);
        attr_pattern    = 4'($urandom);
        attr_function   = 2'($urandom);
        attr_underline  = 1'($urandom);
        attr_invert     = 1'($urandom);
        attr_blink      = 2'($urandom);
        attr_size_horz  = 1'($urandom);
        attr_size_vert  = 1'($urandom);
    endtask

    task automatic drive_cmd(input int gfx, code, gbits, mosaic, x, y, bg, fg, pat, func,
                             ul, inv, blink, sh, sv);
        cmd_gfx         = 1'(gfx);
        cmd_code        = 10'(code);
        cmd_gfx_bits    = 20'(gbits);
        cmd_mosaic      = 1'(mosaic);
        cmd_x           = 7'(x);
        cmd_y           = 6'(y);
        attr_background = 4'(bg);
        attr_foreground = 4'(fg);
        attr_pattern    = 4'(pat);
        attr_function   = 2'(func);
        attr_underline  = 1'(ul);
        attr_invert     = 1'(inv);
        attr_blink      = 2'(blink);
        attr_size_horz  = 1'(sh);
        attr_size_vert  = 1'(sv);
    endtask

    task automatic run_cmd(input int gfx, code, gbits, mosaic, x, y, bg, fg, pat, func,
                           ul, inv, blink, sh, sv, stall_first, rnd_ready);
        int  w, h, ncells, stalls, k;
        bit  done_seen, holding, first_wr;
        logic [31:0] held_a, held_d;

        k = 0;
        while (!cmd_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check_value("cmd_ready_idle", 32'(cmd_ready), 32'd1);

        drive_cmd(gfx, code, gbits, mosaic, x, y, bg, fg, pat, func, ul, inv, blink, sh, sv);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        scramble_inputs();

        w = (gfx != 0) ? 1 : 1 + sh;
        h = (gfx != 0) ? 1 : 1 + sv;
        exp_addr_q.delete();
        exp_data_q.delete();
        ncells   = 0;
        first_wr = model_writable(x, y);
        for (int dy = 0; dy < h; dy++) begin
            for (int dx = 0; dx < w; dx++) begin
                ncells++;
                if (model_writable(x + dx, y + dy)) begin
                    exp_addr_q.push_back(32'(((y + dy) * COLUMNS + x + dx) % (1 << ADDR_WIDTH)));
                    exp_data_q.push_back(model_word(gfx, code, gbits, mosaic, bg, fg, pat, func,
                                                    ul, inv, blink, sh, sv, dx, dy));
                end
            end
        end

        stalls    = 0;
        holding   = 1'b0;
        done_seen = 1'b0;
        held_a    = '0;
        held_d    = '0;
        for (k = 0; k < 200; k++) begin
            if (k < stall_first)
                wr_ready = 1'b0;
            else if (rnd_ready != 0)
                wr_ready = ($urandom_range(0, 3) != 0);
            else
                wr_ready = 1'b1;

            if (k == 0)
                check_value("first_wr_valid", 32'(wr_valid), 32'(first_wr));
            if (holding) begin
                check_value("hold_valid", 32'(wr_valid), 32'd1);
                check_value("hold_addr", 32'(wr_address), held_a);
                check_value("hold_data", wr_data, held_d);
            end
            if (cmd_done) begin
                done_seen = 1'b1;
                break;
            end
            holding = 1'b0;
            if (wr_valid) begin
                if (!wr_ready) begin
                    stalls++;
                    holding = 1'b1;
                    held_a  = 32'(wr_address);
                    held_d  = wr_data;
                end else if (exp_addr_q.size() == 0) begin
                    check_value("extra_write_addr", 32'(wr_address), 32'hFFFF_FFFF);
                end else begin
                    check_value("wr_address", 32'(wr_address), exp_addr_q.pop_front());
                    check_value("wr_data", wr_data, exp_data_q.pop_front());
                end
            end
            @(posedge clk); #1;
        end

        wr_ready = 1'b1;
        check_value("done_seen", 32'(done_seen), 32'd1);
        if (done_seen) begin
            check_value("done_latency", 32'(k), 32'(ncells + stalls));
            check_value("next_x", 32'(next_x), 32'((x + w) % 256));
            check_value("missing_writes", 32'(exp_addr_q.size()), 32'd0);
            check_value("ready_in_done", 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
            check_value("done_pulse_len", 32'(cmd_done), 32'd0);
            check_value("ready_after_done", 32'(cmd_ready), 32'd1);
        end
    endtask

    task automatic reset_mid_command();
        drive_cmd(0, 'h123, 0, 0, 3, 4, 1, 2, 3, 1, 1, 0, 2, 0, 1);
        wr_ready  = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_value("rst_mid_cell0_addr", 32'(wr_address), 32'(4 * COLUMNS + 3));
        @(posedge clk); #1;
        check_value("rst_mid_cell1_valid", 32'(wr_valid), 32'd1);
        check_value("rst_mid_cell1_addr", 32'(wr_address), 32'(5 * COLUMNS + 3));
        reset_n = 1'b0;
        #1;
        check_value("rst_async_valid", 32'(wr_valid), 32'd0);
        check_value("rst_async_ready", 32'(cmd_ready), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check_value("rst_no_done", 32'(cmd_done), 32'd0);
        end
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_value("rst_release_ready", 32'(cmd_ready), 32'd1);
        check_value("rst_release_done", 32'(cmd_done), 32'd0);
        check_value("rst_release_valid", 32'(wr_valid), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        wr_ready  = 1'b1;
        scramble_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_value("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        check_value("reset_wr_valid", 32'(wr_valid), 32'd0);
        check_value("reset_wr_address", 32'(wr_address), 32'd0);
        check_value("reset_wr_data", wr_data, 32'd0);
        check_value("reset_cmd_done", 32'(cmd_done), 32'd0);
        check_value("reset_next_x", 32'(next_x), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_value("ready_after_reset", 32'(cmd_ready), 32'd1);

        //      gfx code   gbits    mos x   y   bg fg pat fn ul iv bl sh sv stall rnd
        run_cmd(0, 'h041, 0,       0,  0,  0,  0, 7, 0,  0, 0, 0, 0, 0, 0, 0,    0);
        run_cmd(0, 'h041, 0,       0,  10, 5,  0, 7, 0,  0, 0, 0, 0, 1, 1, 0,    0);
        run_cmd(1, 0,     'hFFFFF, 1,  2,  0,  3, 5, 0,  0, 0, 0, 0, 1, 1, 0,    0);
        run_cmd(0, 'h2A5, 0,       0,  7,  9,  9, 6, 5,  2, 1, 1, 3, 0, 0, 3,    0);
        run_cmd(0, 'h041, 0,       0,  79, 50, 4, 2, 0,  0, 0, 0, 0, 1, 0, 0,    0);
        run_cmd(0, 'h3FF, 0,       0,  79, 50, 4, 2, 0,  0, 0, 0, 0, 1, 1, 2,    0);
        reset_mid_command();

        for (int i = 0; i < 150; i++) begin
            int rx;
            rx = ($urandom_range(0, 3) == 0) ? $urandom_range(76, 127) : $urandom_range(0, 79);
            run_cmd(($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 1023),
                    $urandom_range(0, 20'hFFFFF), $urandom_range(0, 1), rx,
                    $urandom_range(0, 63), $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 2), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
